// File: rtl/icape2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icape2_pkg
//  Description : Shared constants, FSM state encoding and the per-byte
//                bit-reversal helper for the ICAPE2 multiboot writer.
//  Revision    : 1.0  initial release
// ============================================================================
package icape2_pkg;

  // Configuration packet words (pre-swap, as written in the UG470 tables)
  localparam logic [31:0] DUMMY     = 32'hFFFF_FFFF;
  localparam logic [31:0] SYNC      = 32'hAA99_5566;
  localparam logic [31:0] NOOP      = 32'h2000_0000;
  localparam logic [31:0] WR_WBSTAR = 32'h3002_0001;
  localparam logic [31:0] WR_CMD    = 32'h3000_8001;
  localparam logic [31:0] CMD_IPROG = 32'h0000_000F;

  localparam int unsigned N_WORDS   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ICAPE2 expects each byte bit-reversed relative to the bitstream order
  function automatic logic [31:0] bitswap32(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*k+j] = w[8*k+7-j];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icape2_sim_stub.sv
`default_nettype none
// ============================================================================
//  Module      : ICAPE2
//  Description : Port-compatible behavioural stand-in for the Xilinx ICAPE2
//                primitive, used when the UNISIM library is not available.
//                Implementation flows use the vendor primitive instead.
//  Revision    : 1.0  initial release
// ============================================================================
module ICAPE2 #(
  parameter ICAP_WIDTH = "X32"
) (
  input  logic        CLK,
  input  logic        CSIB,
  input  logic [31:0] I,
  input  logic        RDWRB,
  output logic [31:0] O
);

  logic [31:0] o_q;

  // Echo the last written word so the readback port has defined behaviour
  always_ff @(posedge CLK) begin
    if (!CSIB && !RDWRB) o_q <= I;
  end

  assign O = (ICAP_WIDTH == "X32") ? o_q : 32'h0000_0000;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchronizer plus saturating debounce counter that
//                emits a single-cycle press pulse per accepted key press.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press,
  output logic key_sync
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          press_d;

  assign key_sync = sync_q[1];

  // Bring the raw button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], key_in};
  end

  // Count stable-high cycles; saturate so only one pulse fires until release
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!key_sync) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DEBOUNCE_CNT)) begin
      cnt_d   = cnt_q + 1'b1;
      press_d = (cnt_q == CW'(DEBOUNCE_CNT - 1));
    end
  end

  // Counter and registered press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      press <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      press <= press_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/icape2_write_reg_top.sv
`default_nettype none
// ============================================================================
//  Module      : icape2_write_reg_top
//  Description : Debounced push-button triggers an ICAPE2 write of WBSTAR
//                followed by IPROG, causing a warm reboot from flash.
//  Revision    : 1.0  initial release
// ============================================================================
module icape2_write_reg_top
  import icape2_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000,
  parameter logic [31:0] WBSTAR_ADDR  = 32'h0010_0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key
);

  logic        press;
  logic        key_sync;
  state_t      state;
  state_t      state_d;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic [31:0] rom_word;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_din;
  logic [31:0] icap_o_unused;

  key_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_key_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key),
    .press    (press),
    .key_sync (key_sync)
  );

  // Next-state: one press starts a fixed 8-word burst that cannot be cut short
  always_comb begin
    state_d = state;
    idx_d   = idx_q;
    case (state)
      IDLE: begin
        if (press) begin
          state_d = WRITE;
          idx_d   = 3'd0;
        end
      end
      WRITE: begin
        if (idx_q == 3'(N_WORDS - 1)) begin
          state_d = DONE;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        if (!key_sync) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Word ROM, addressed with the next index so the output register lines up
  always_comb begin
    rom_word = DUMMY;
    case (idx_d)
      3'd0:    rom_word = DUMMY;
      3'd1:    rom_word = SYNC;
      3'd2:    rom_word = NOOP;
      3'd3:    rom_word = WR_WBSTAR;
      3'd4:    rom_word = WBSTAR_ADDR;
      3'd5:    rom_word = WR_CMD;
      3'd6:    rom_word = CMD_IPROG;
      3'd7:    rom_word = NOOP;
      default: rom_word = DUMMY;
    endcase
  end

  // State and registered ICAPE2 drive; reset deselects the port immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx_q      <= 3'd0;
      icap_csib  <= 1'b1;
      icap_din   <= 32'hFFFF_FFFF;
      icap_rdwrb <= 1'b0;
    end else begin
      state      <= state_d;
      idx_q      <= idx_d;
      icap_csib  <= (state_d != WRITE);
      icap_din   <= (state_d == WRITE) ? bitswap32(rom_word) : 32'hFFFF_FFFF;
      icap_rdwrb <= 1'b0;
    end
  end

  ICAPE2 #(
    .ICAP_WIDTH ("X32")
  ) u_icape2 (
    .CLK   (clk),
    .CSIB  (icap_csib),
    .I     (icap_din),
    .RDWRB (icap_rdwrb),
    .O     (icap_o_unused)
  );

endmodule
`default_nettype wire

// File: tb/tb_icape2_write_reg_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icape2_write_reg_top
//  Description : Scoreboard bench for the ICAPE2 multiboot writer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icape2_write_reg_top;

  localparam int unsigned DEB = 16;

  logic clk;
  logic rst_n;
  logic key;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [31:0] word;
  } exp_t;

  exp_t word_q[$];
  int   press_q[$];

  logic [31:0] exp_words [8] = '{
    32'hFFFF_FFFF, 32'h5599_AA66, 32'h0400_0000, 32'h0C40_0080,
    32'h0008_0000, 32'h0C00_0180, 32'h0000_00F0, 32'h0400_0000
  };

  icape2_write_reg_top #(
    .DEBOUNCE_CNT (DEB),
    .WBSTAR_ADDR  (32'h0010_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Push the expected press cycle and burst for a key driven high at cycle c
  task automatic expect_seq(input int c, input int n_words);
    press_q.push_back(c + 2 + DEB);
    for (int i = 0; i < n_words; i++) begin
      exp_t e;
      e.cyc  = c + 3 + DEB + i;
      e.word = exp_words[i];
      word_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((word_q.size() != 0 || press_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, word_q.size() + press_q.size(), 0);
  endtask

  // Monitor: every ICAPE2 access and press pulse must match the scoreboard
  always @(negedge clk) begin
    #1;
    chk("rdwrb", {31'b0, dut.icap_rdwrb}, 32'h0);
    if (dut.press === 1'b1) begin
      if (press_q.size() == 0) chk("press_spurious", {31'b0, dut.press}, 32'h0);
      else                     chk("press_cycle", cyc, press_q.pop_front());
    end
    if (dut.icap_csib !== 1'b1) begin
      if (word_q.size() == 0) begin
        chk("csib_spurious", {31'b0, dut.icap_csib}, 32'h1);
      end else begin
        exp_t e;
        e = word_q.pop_front();
        chk("word_cycle", cyc, e.cyc);
        chk("word_data", dut.icap_din, e.word);
      end
    end else begin
      chk("din_idle", dut.icap_din, 32'hFFFF_FFFF);
    end
  end

  initial begin
    int c;
    rst_n = 1'b0;
    key   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csib", {31'b0, dut.icap_csib}, 32'h1);
    chk("rst_din", dut.icap_din, 32'hFFFF_FFFF);
    chk("rst_state", {30'b0, dut.state}, 32'h0);
    chk("rst_press", {31'b0, dut.press}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Quiet key: monitor flags any press or CSIB activity
    repeat (100) @(negedge clk);
    chk("idle_csib", {31'b0, dut.icap_csib}, 32'h1);

    // First press, key held through and beyond the burst
    @(negedge clk);
    key = 1'b1;
    c = cyc;
    expect_seq(c, 8);
    wait_drain("seq1_drain");
    @(negedge clk);
    chk("seq1_csib_after", {31'b0, dut.icap_csib}, 32'h1);
    repeat (60) @(negedge clk);
    chk("held_state_done", {30'b0, dut.state}, 32'h2);

    // Release returns to IDLE
    key = 1'b0;
    repeat (4) @(negedge clk);
    chk("release_idle", {30'b0, dut.state}, 32'h0);

    // Short glitch must not trigger
    key = 1'b1;
    repeat (10) @(negedge clk);
    key = 1'b0;
    repeat (40) @(negedge clk);
    chk("glitch_csib", {31'b0, dut.icap_csib}, 32'h1);

    // Second full press gives an identical burst
    key = 1'b1;
    c = cyc;
    expect_seq(c, 8);
    wait_drain("seq2_drain");
    key = 1'b0;
    repeat (6) @(negedge clk);

    // Abort during word 3: only words 0..3 may appear
    key = 1'b1;
    c = cyc;
    expect_seq(c, 4);
    while (cyc < c + 3 + DEB + 3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    key   = 1'b0;
    #1;
    chk("abort_csib", {31'b0, dut.icap_csib}, 32'h1);
    chk("abort_state", {30'b0, dut.state}, 32'h0);
    chk("abort_din", dut.icap_din, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_drain", word_q.size() + press_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
